// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
package uart_rx_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID        = 8;

  // Oversample-counter values at which the last / middle tick of a bit lands.
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMP_MID  = 4'(MID - 1);

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO. The head entry is held in a register so the
// read data stays put while the FIFO is empty.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;
  logic             head_load;
  logic [WIDTH-1:0] head_next;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + AW'(1);

  // Next head value: the following entry after a pop, or the incoming byte
  // when it becomes the head (empty FIFO, or single entry being popped).
  always_comb begin
    head_load = 1'b0;
    head_next = rd_data;
    if (do_pop) begin
      if (do_push && (wr_ptr == rd_next)) begin
        head_load = 1'b1;
        head_next = wr_data;
      end else if (count != (AW+1)'(1)) begin
        head_load = 1'b1;
        head_next = mem[rd_next];
      end else begin
        head_load = 1'b0;
      end
    end else if (do_push && empty) begin
      head_load = 1'b1;
      head_next = wr_data;
    end else begin
      head_load = 1'b0;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      if (head_load) rd_data <= head_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver with 16x oversampling, byte FIFO and error flags.
module uart_rx_monitor
  import uart_rx_monitor_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        rx_i,
  input  logic [DIV_W-1:0]            divisor_i,
  output logic [7:0]                  m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  input  logic                        clear_i
);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] tick_cnt;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             tick;
  logic             mid_samp;
  logic             last_samp;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign div_eff   = (divisor_i == '0) ? DIV_W'(1) : divisor_i;
  assign tick      = (state != IDLE) && (tick_cnt == '0);
  assign mid_samp  = tick && (samp_cnt == SAMP_MID);
  assign last_samp = tick && (samp_cnt == SAMP_LAST);
  assign push      = (state == STOP) && last_samp && rx_s;
  assign pop       = m_valid_o && m_ready_i;
  assign m_valid_o = !fifo_empty;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with tick generator, oversample/bit counters and shift register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      div_r       <= DIV_W'(1);
      tick_cnt    <= '0;
      samp_cnt    <= 4'd0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (state != IDLE) begin
        tick_cnt <= (tick_cnt == '0) ? (div_r - DIV_W'(1)) : (tick_cnt - DIV_W'(1));
        if (tick) samp_cnt <= samp_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            div_r    <= div_eff;
            tick_cnt <= div_eff - DIV_W'(1);
            samp_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
          end
        end
        START: begin
          if (mid_samp) begin
            samp_cnt <= 4'd0;
            state    <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_samp) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (last_samp) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      overrun_o <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_o <= 1'b1;
    end else if (clear_i) begin
      overrun_o <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .push    (push),
    .wr_data (shift),
    .pop     (pop),
    .rd_data (m_data_o),
    .count   (count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: serial frame driver, byte
// scoreboard on the output stream, and directed corner-case sequences.
module tb_uart_rx_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] divisor;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  count;
  logic        frame_err;
  logic        overrun;
  logic        clear;

  int tests   = 0;
  int fails   = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic        stop;
    int          exp_err;
  } vec_t;

  vec_t vecs [7];

  uart_rx_monitor #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .rx_i        (rx),
    .divisor_i   (divisor),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .count_o     (count),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .clear_i     (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream scoreboard and frame-error pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_err) err_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream: got unexpected byte 0x%0h, expected none", m_data);
        end else begin
          check("stream", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Drive one 8N1 frame; called and returns just after a falling edge.
  task automatic send_frame(input logic [7:0] d, input int div, input logic stop);
    rx = 1'b0;
    repeat (16 * div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16 * div) @(negedge clk);
    end
    rx = stop;
    repeat (16 * div) @(negedge clk);
  endtask

  // Bounded wait for the FIFO to drain.
  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (count != 5'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {27'd0, count}, 32'd0);
  endtask

  initial begin
    int e0;
    int eff;
    rst_n   = 1'b0;
    rx      = 1'b1;
    divisor = 16'd26;
    m_ready = 1'b0;
    clear   = 1'b0;

    vecs[0] = '{16'd0,  8'h5A, 1'b1, 0};
    vecs[1] = '{16'd1,  8'hFF, 1'b1, 0};
    vecs[2] = '{16'd3,  8'h00, 1'b1, 0};
    vecs[3] = '{16'd7,  8'h81, 1'b1, 0};
    vecs[4] = '{16'd2,  8'hE7, 1'b0, 1};
    vecs[5] = '{16'd5,  8'h33, 1'b1, 0};
    vecs[6] = '{16'd26, 8'hA0, 1'b1, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Two back-to-back frames at divisor 26.
    m_ready = 1'b1;
    e0 = err_cnt;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h0A);
    send_frame(8'h41, 26, 1'b1);
    send_frame(8'h0A, 26, 1'b1);
    repeat (40) @(negedge clk);
    wait_empty("b2b_drain", 200);
    check("b2b_ferr", err_cnt - e0, 32'd0);
    check("b2b_ovr", {31'd0, overrun}, 32'd0);
    check("b2b_q", exp_q.size(), 32'd0);

    // Table of frames with varied divisors, including 0 and a bad stop bit.
    for (int v = 0; v < 7; v++) begin
      divisor = vecs[v].div;
      eff = (vecs[v].div == 16'd0) ? 1 : int'(vecs[v].div);
      e0 = err_cnt;
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, eff, vecs[v].stop);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_ferr", v), err_cnt - e0, vecs[v].exp_err);
      wait_empty($sformatf("vec%0d_drain", v), 200);
    end
    check("vec_q", exp_q.size(), 32'd0);

    // Short low glitch on the line: rejected at the start-bit re-sample.
    divisor = 16'd26;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (130) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_count", {27'd0, count}, 32'd0);
    check("glitch_ferr", err_cnt - e0, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 26, 1'b1);
    wait_empty("glitch_next", 200);

    // Divisor change mid-frame only affects the following frame.
    divisor = 16'd8;
    exp_q.push_back(8'h96);
    fork
      send_frame(8'h96, 8, 1'b1);
      begin
        repeat (500) @(negedge clk);
        divisor = 16'd3;
      end
    join
    exp_q.push_back(8'h69);
    send_frame(8'h69, 3, 1'b1);
    wait_empty("divchg_drain", 200);
    check("divchg_q", exp_q.size(), 32'd0);

    // Stop bit low followed by a long break: exactly one error pulse.
    divisor = 16'd26;
    e0 = err_cnt;
    send_frame(8'h55, 26, 1'b0);
    repeat (40 * 16 * 26) @(negedge clk);
    check("brk_ferr", err_cnt - e0, 32'd1);
    check("brk_count", {27'd0, count}, 32'd0);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("brk_ferr_after", err_cnt - e0, 32'd1);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 26, 1'b1);
    wait_empty("brk_next", 200);

    // Overrun: 17 bytes into a 16-entry FIFO with no consumer.
    divisor = 16'd4;
    m_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 4, 1'b1);
    end
    repeat (20) @(negedge clk);
    check("ovr_count", {27'd0, count}, 32'd16);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_head", {24'd0, m_data}, 32'h00);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("ovr_clear", {31'd0, overrun}, 32'd0);
    m_ready = 1'b1;
    wait_empty("ovr_drain", 200);
    check("ovr_q", exp_q.size(), 32'd0);

    // Full FIFO with a pop in the exact cycle the next byte is pushed.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 4, 1'b1);
    end
    check("full_count", {27'd0, count}, 32'd16);
    exp_q.push_back(8'h30);
    fork
      send_frame(8'h30, 4, 1'b1);
      begin
        repeat (152 * 4 + 2) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("pp_count", {27'd0, count}, 32'd16);
    check("pp_ovr", {31'd0, overrun}, 32'd0);
    check("pp_head", {24'd0, m_data}, 32'h21);
    m_ready = 1'b1;
    wait_empty("pp_drain", 200);
    check("pp_q", exp_q.size(), 32'd0);

    // Reset during data bit 3, with an unread byte already buffered.
    m_ready = 1'b0;
    send_frame(8'h77, 4, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst_count", {27'd0, count}, 32'd1);
    rx = 1'b0;
    repeat (16 * 4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h3C >> i) & 8'h01;
      repeat (16 * 4) @(negedge clk);
    end
    rx = 1'b1;
    repeat (8 * 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_count", {27'd0, count}, 32'd0);
    check("mid_rst_data", {24'd0, m_data}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    m_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 4, 1'b1);
    wait_empty("post_rst_drain", 200);
    check("post_rst_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
